// File: rtl/prefetch_dma_scheduler.sv
// Arbitrates one DMA request port between demand misses and a line-aligned prefetch queue.
// Demand misses take priority; prefetch issue is capped by an outstanding-fill limit.
module prefetch_dma_scheduler #(
  parameter int addr_width_p         = 32,
  parameter int block_offset_width_p = 6,
  parameter int queue_depth_p        = 4,
  parameter int max_outstanding_p    = 2
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   demand_v_i,
  input  logic [addr_width_p-1:0]                demand_addr_i,
  output logic                                   demand_ready_o,
  input  logic                                   pf_v_i,
  input  logic [addr_width_p-1:0]                pf_addr_i,
  input  logic                                   pf_enable_i,
  input  logic                                   flush_i,
  output logic                                   pf_drop_o,
  output logic                                   dma_v_o,
  output logic [addr_width_p-1:0]                dma_addr_o,
  output logic                                   dma_is_prefetch_o,
  input  logic                                   dma_ready_i,
  input  logic                                   dma_pf_done_i,
  output logic [$clog2(queue_depth_p+1)-1:0]     queue_count_o,
  output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o
);

  localparam int line_width_lp  = addr_width_p - block_offset_width_p;
  localparam int ptr_width_lp   = $clog2(queue_depth_p);
  localparam int count_width_lp = $clog2(queue_depth_p + 1);
  localparam int out_width_lp   = $clog2(max_outstanding_p + 1);
  localparam logic [count_width_lp-1:0] full_count_lp = count_width_lp'(queue_depth_p);
  localparam logic [out_width_lp-1:0]   max_out_lp    = out_width_lp'(max_outstanding_p);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEMAND   = 2'd1,
    ST_PREFETCH = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [line_width_lp-1:0]  line_q [queue_depth_p];
  logic [queue_depth_p-1:0]  valid_q, valid_d;
  logic [ptr_width_lp-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [count_width_lp-1:0] count_q, count_d;
  logic [out_width_lp-1:0]   outstanding_q, outstanding_d;
  logic                      dma_v_q, dma_v_d, dma_is_pf_q, dma_is_pf_d;
  logic [addr_width_p-1:0]   dma_addr_q, dma_addr_d;
  logic                      pf_drop_q, pf_drop_d;

  logic demand_ready, demand_accept, load_demand, load_pf, pop, push;
  logic dma_fire, pf_fire, pf_done_eff, pf_req, pf_hit, same_line;
  logic [line_width_lp-1:0] pf_line, demand_line;
  logic unused_pf_offset;

  assign pf_line          = pf_addr_i[addr_width_p-1:block_offset_width_p];
  assign demand_line      = demand_addr_i[addr_width_p-1:block_offset_width_p];
  assign unused_pf_offset = ^pf_addr_i[block_offset_width_p-1:0];

  // FSM: state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load_demand)  state_d = ST_DEMAND;
        else if (load_pf) state_d = ST_PREFETCH;
      end
      ST_DEMAND, ST_PREFETCH: if (dma_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs. A squashed head is popped without issuing anything.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    demand_ready = 1'b0;
    load_demand  = 1'b0;
    load_pf      = 1'b0;
    pop          = 1'b0;
    dma_fire     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        demand_ready = 1'b1;
        if (demand_v_i) begin
          load_demand = 1'b1;
        end else if (!flush_i && count_q != '0) begin
          if (!valid_q[rd_ptr_q]) begin
            pop = 1'b1;
          end else if (outstanding_q < max_out_lp) begin
            pop     = 1'b1;
            load_pf = 1'b1;
          end
        end
      end
      default: dma_fire = dma_ready_i;
    endcase
  end

  assign demand_accept = demand_v_i & demand_ready;
  assign pf_fire       = dma_fire & (state_q == ST_PREFETCH);
  assign pf_done_eff   = dma_pf_done_i & (outstanding_q != '0);

  // Duplicate filter covers valid queue entries and a prefetch still waiting on the port.
  always_comb begin
    pf_hit = 1'b0;
    for (int i = 0; i < queue_depth_p; i++) begin
      if (valid_q[i] && line_q[i] == pf_line) pf_hit = 1'b1;
    end
    if (dma_v_q && dma_is_pf_q &&
        dma_addr_q[addr_width_p-1:block_offset_width_p] == pf_line) pf_hit = 1'b1;
  end

  assign pf_req    = pf_v_i & pf_enable_i & ~flush_i;
  assign push      = pf_req & ~pf_hit & ((count_q != full_count_lp) | pop);
  assign pf_drop_d = pf_req & ~push;
  assign same_line = demand_accept & (demand_line == pf_line);

  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (demand_accept) begin
      for (int i = 0; i < queue_depth_p; i++) begin
        if (line_q[i] == demand_line) valid_d[i] = 1'b0;
      end
    end
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + ptr_width_lp'(1);
    end
    // On a full queue wr_ptr equals rd_ptr, so the push lands after the pop clears the slot.
    if (push) begin
      valid_d[wr_ptr_q] = ~same_line;
      wr_ptr_d          = wr_ptr_q + ptr_width_lp'(1);
    end
    count_d = count_q + count_width_lp'(push) - count_width_lp'(pop);
    if (flush_i) begin
      valid_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    case ({pf_fire, pf_done_eff})
      2'b10:   outstanding_d = outstanding_q + out_width_lp'(1);
      2'b01:   outstanding_d = outstanding_q - out_width_lp'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_comb begin
    dma_v_d     = dma_v_q;
    dma_addr_d  = dma_addr_q;
    dma_is_pf_d = dma_is_pf_q;
    if (load_demand) begin
      dma_v_d     = 1'b1;
      dma_addr_d  = demand_addr_i;
      dma_is_pf_d = 1'b0;
    end else if (load_pf) begin
      dma_v_d     = 1'b1;
      dma_addr_d  = {line_q[rd_ptr_q], {block_offset_width_p{1'b0}}};
      dma_is_pf_d = 1'b1;
    end else if (dma_fire) begin
      dma_v_d = 1'b0;
    end
  end

  // NOTE: the line storage has no reset; the valid bits and count alone define occupancy.
  always_ff @(posedge clk_i) begin
    if (push) line_q[wr_ptr_q] <= pf_line;
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      dma_v_q       <= 1'b0;
      dma_addr_q    <= '0;
      dma_is_pf_q   <= 1'b0;
      pf_drop_q     <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      dma_v_q       <= dma_v_d;
      dma_addr_q    <= dma_addr_d;
      dma_is_pf_q   <= dma_is_pf_d;
      pf_drop_q     <= pf_drop_d;
    end
  end

  assign demand_ready_o    = demand_ready & ~reset_i;
  assign pf_drop_o         = pf_drop_q;
  assign dma_v_o           = dma_v_q;
  assign dma_addr_o        = dma_addr_q;
  assign dma_is_prefetch_o = dma_is_pf_q;
  assign queue_count_o     = count_q;
  assign outstanding_o     = outstanding_q;

endmodule

// File: tb/tb_prefetch_dma_scheduler.sv
// Directed bench for prefetch_dma_scheduler: one task per scenario with hand-derived expectations.
module tb_prefetch_dma_scheduler;

  logic        clk_i, reset_i;
  logic        demand_v_i, pf_v_i, pf_enable_i, flush_i, dma_ready_i, dma_pf_done_i;
  logic [31:0] demand_addr_i, pf_addr_i;
  logic        demand_ready_o, pf_drop_o, dma_v_o, dma_is_prefetch_o;
  logic [31:0] dma_addr_o;
  logic [2:0]  queue_count_o;
  logic [1:0]  outstanding_o;

  int n_tests = 0;
  int n_fail  = 0;

  prefetch_dma_scheduler dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .demand_v_i(demand_v_i), .demand_addr_i(demand_addr_i), .demand_ready_o(demand_ready_o),
    .pf_v_i(pf_v_i), .pf_addr_i(pf_addr_i), .pf_enable_i(pf_enable_i), .flush_i(flush_i),
    .pf_drop_o(pf_drop_o), .dma_v_o(dma_v_o), .dma_addr_o(dma_addr_o),
    .dma_is_prefetch_o(dma_is_prefetch_o), .dma_ready_i(dma_ready_i),
    .dma_pf_done_i(dma_pf_done_i), .queue_count_o(queue_count_o), .outstanding_o(outstanding_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // {valid, is_prefetch, addr}
  function automatic logic [33:0] dma_snap();
    return {dma_v_o, dma_is_prefetch_o, dma_addr_o};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    demand_v_i = 1'b0; demand_addr_i = '0;
    pf_v_i = 1'b0; pf_addr_i = '0; pf_enable_i = 1'b1;
    flush_i = 1'b0; dma_ready_i = 1'b1; dma_pf_done_i = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset_i = 1'b1;
    tick(); tick();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_i = 1'b1;
    tick();
    n_tests++;
    if ({dma_v_o, pf_drop_o, demand_ready_o, queue_count_o, outstanding_o} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b drop=%b rdy=%b cnt=%0d out=%0d, expected all 0",
               dma_v_o, pf_drop_o, demand_ready_o, queue_count_o, outstanding_o);
    end
    reset_i = 1'b0;
    tick();
    n_tests++;
    if (demand_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_idle_ready: got %b, expected 1", demand_ready_o);
    end
  endtask

  task automatic test_demand();
    apply_reset();
    demand_v_i = 1'b1; demand_addr_i = 32'h1044;
    tick();
    demand_v_i = 1'b0;
    n_tests++;
    if (dma_snap() !== {2'b10, 32'h1044}) begin
      n_fail++; $display("FAIL demand_issue: got %h, expected %h", dma_snap(), {2'b10, 32'h1044});
    end
    n_tests++;
    if (demand_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL demand_busy_ready: got %b, expected 0", demand_ready_o);
    end
    tick();
    n_tests++;
    if ({dma_v_o, demand_ready_o, outstanding_o} !== 4'b0100) begin
      n_fail++;
      $display("FAIL demand_done: got v=%b rdy=%b out=%0d, expected v=0 rdy=1 out=0",
               dma_v_o, demand_ready_o, outstanding_o);
    end
  endtask

  task automatic test_prefetch();
    apply_reset();
    pf_v_i = 1'b1; pf_addr_i = 32'h2010;
    tick();
    pf_v_i = 1'b0;
    n_tests++;
    if ({dma_v_o, queue_count_o} !== 4'b0001) begin
      n_fail++; $display("FAIL pf_queued: got v=%b cnt=%0d, expected v=0 cnt=1", dma_v_o, queue_count_o);
    end
    tick();
    n_tests++;
    if (dma_snap() !== {2'b11, 32'h2000} || queue_count_o !== 3'd0) begin
      n_fail++;
      $display("FAIL pf_issue: got %h cnt=%0d, expected %h cnt=0", dma_snap(), queue_count_o, {2'b11, 32'h2000});
    end
    tick();
    n_tests++;
    if ({dma_v_o, outstanding_o} !== 3'b001) begin
      n_fail++; $display("FAIL pf_outstanding: got v=%b out=%0d, expected v=0 out=1", dma_v_o, outstanding_o);
    end
    dma_pf_done_i = 1'b1;
    tick();
    n_tests++;
    if (outstanding_o !== 2'd0) begin
      n_fail++; $display("FAIL pf_fill_done: got %0d, expected 0", outstanding_o);
    end
    tick();
    dma_pf_done_i = 1'b0;
    n_tests++;
    if (outstanding_o !== 2'd0) begin
      n_fail++; $display("FAIL pf_no_underflow: got %0d, expected 0", outstanding_o);
    end
  endtask

  task automatic test_duplicate();
    apply_reset();
    dma_ready_i = 1'b0;
    demand_v_i = 1'b1; demand_addr_i = 32'h9000;
    tick();
    demand_v_i = 1'b0;
    pf_v_i = 1'b1; pf_addr_i = 32'h3000;
    tick();
    pf_addr_i = 32'h3020;
    tick();
    pf_v_i = 1'b0;
    n_tests++;
    if ({queue_count_o, pf_drop_o} !== 4'b0011) begin
      n_fail++; $display("FAIL dup_drop: got cnt=%0d drop=%b, expected cnt=1 drop=1", queue_count_o, pf_drop_o);
    end
    tick();
    n_tests++;
    if ({queue_count_o, pf_drop_o} !== 4'b0010) begin
      n_fail++; $display("FAIL dup_drop_pulse: got cnt=%0d drop=%b, expected cnt=1 drop=0", queue_count_o, pf_drop_o);
    end
    pf_v_i = 1'b1; pf_enable_i = 1'b0; pf_addr_i = 32'h3040;
    tick();
    pf_v_i = 1'b0; pf_enable_i = 1'b1;
    n_tests++;
    if ({queue_count_o, pf_drop_o} !== 4'b0010) begin
      n_fail++; $display("FAIL pf_disabled: got cnt=%0d drop=%b, expected cnt=1 drop=0", queue_count_o, pf_drop_o);
    end
  endtask

  task automatic test_pending_dup();
    apply_reset();
    dma_ready_i = 1'b0;
    pf_v_i = 1'b1; pf_addr_i = 32'hC000;
    tick();
    pf_v_i = 1'b0;
    tick();
    pf_v_i = 1'b1; pf_addr_i = 32'hC030;
    tick();
    pf_v_i = 1'b0;
    n_tests++;
    if ({dma_snap(), queue_count_o, pf_drop_o} !== {2'b11, 32'hC000, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL pending_dup: got dma=%h cnt=%0d drop=%b, expected dma=%h cnt=0 drop=1",
               dma_snap(), queue_count_o, pf_drop_o, {2'b11, 32'hC000});
    end
  endtask

  task automatic test_queue_full();
    apply_reset();
    dma_ready_i = 1'b0;
    demand_v_i = 1'b1; demand_addr_i = 32'h9000;
    tick();
    demand_v_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pf_v_i = 1'b1; pf_addr_i = 32'hA000 + 32'(i * 64);
      tick();
      n_tests++;
      if ({queue_count_o, pf_drop_o} !== {3'((i < 4) ? i + 1 : 4), (i == 4)}) begin
        n_fail++;
        $display("FAIL fill_%0d: got cnt=%0d drop=%b, expected cnt=%0d drop=%b",
                 i, queue_count_o, pf_drop_o, (i < 4) ? i + 1 : 4, (i == 4));
      end
    end
    pf_addr_i = 32'hA140; flush_i = 1'b1;
    tick();
    pf_v_i = 1'b0; flush_i = 1'b0;
    n_tests++;
    if ({dma_snap(), queue_count_o, pf_drop_o} !== {2'b10, 32'h9000, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL flush: got dma=%h cnt=%0d drop=%b, expected dma=%h cnt=0 drop=0",
               dma_snap(), queue_count_o, pf_drop_o, {2'b10, 32'h9000});
    end
    for (int i = 0; i < 4; i++) begin
      pf_v_i = 1'b1; pf_addr_i = 32'hA000 + 32'(i * 64);
      tick();
    end
    pf_v_i = 1'b0; dma_ready_i = 1'b1;
    tick();
    pf_v_i = 1'b1; pf_addr_i = 32'hA100;
    tick();
    pf_v_i = 1'b0;
    n_tests++;
    if ({dma_snap(), queue_count_o, pf_drop_o} !== {2'b11, 32'hA000, 3'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL full_push_pop: got dma=%h cnt=%0d drop=%b, expected dma=%h cnt=4 drop=0",
               dma_snap(), queue_count_o, pf_drop_o, {2'b11, 32'hA000});
    end
    dma_pf_done_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick(); tick();
      n_tests++;
      if (dma_snap() !== {2'b11, 32'hA000 + 32'(k * 64)}) begin
        n_fail++;
        $display("FAIL wrap_order_%0d: got %h, expected %h", k, dma_snap(), {2'b11, 32'hA000 + 32'(k * 64)});
      end
    end
    dma_pf_done_i = 1'b0;
  endtask

  task automatic test_limit();
    apply_reset();
    pf_v_i = 1'b1; pf_addr_i = 32'h4100;
    tick();
    pf_addr_i = 32'h4200;
    tick();
    pf_addr_i = 32'h4000;
    tick();
    pf_v_i = 1'b0;
    tick(); tick(); tick();
    n_tests++;
    if ({dma_v_o, queue_count_o, outstanding_o} !== {1'b0, 3'd1, 2'd2}) begin
      n_fail++;
      $display("FAIL limit_hold: got v=%b cnt=%0d out=%0d, expected v=0 cnt=1 out=2",
               dma_v_o, queue_count_o, outstanding_o);
    end
    tick();
    n_tests++;
    if ({dma_v_o, queue_count_o} !== {1'b0, 3'd1}) begin
      n_fail++; $display("FAIL limit_hold2: got v=%b cnt=%0d, expected v=0 cnt=1", dma_v_o, queue_count_o);
    end
    dma_pf_done_i = 1'b1;
    tick();
    dma_pf_done_i = 1'b0;
    n_tests++;
    if ({dma_v_o, outstanding_o} !== {1'b0, 2'd1}) begin
      n_fail++; $display("FAIL limit_done: got v=%b out=%0d, expected v=0 out=1", dma_v_o, outstanding_o);
    end
    tick();
    n_tests++;
    if (dma_snap() !== {2'b11, 32'h4000} || queue_count_o !== 3'd0) begin
      n_fail++;
      $display("FAIL limit_release: got %h cnt=%0d, expected %h cnt=0", dma_snap(), queue_count_o, {2'b11, 32'h4000});
    end
    dma_pf_done_i = 1'b1;
    tick();
    dma_pf_done_i = 1'b0;
    n_tests++;
    if (outstanding_o !== 2'd1) begin
      n_fail++; $display("FAIL inc_dec_same_cycle: got %0d, expected 1", outstanding_o);
    end
  endtask

  task automatic test_squash();
    apply_reset();
    pf_v_i = 1'b1; pf_addr_i = 32'h5000;
    tick();
    pf_v_i = 1'b0;
    demand_v_i = 1'b1; demand_addr_i = 32'h5008;
    tick();
    demand_v_i = 1'b0;
    n_tests++;
    if (dma_snap() !== {2'b10, 32'h5008} || queue_count_o !== 3'd1) begin
      n_fail++;
      $display("FAIL squash_demand: got %h cnt=%0d, expected %h cnt=1", dma_snap(), queue_count_o, {2'b10, 32'h5008});
    end
    tick(); tick();
    n_tests++;
    if ({dma_v_o, queue_count_o} !== {1'b0, 3'd0}) begin
      n_fail++; $display("FAIL squash_silent_pop: got v=%b cnt=%0d, expected v=0 cnt=0", dma_v_o, queue_count_o);
    end
    tick();
    n_tests++;
    if (dma_v_o !== 1'b0) begin
      n_fail++; $display("FAIL squash_no_issue: got v=%b addr=%h, expected v=0", dma_v_o, dma_addr_o);
    end
  endtask

  task automatic test_same_cycle_squash();
    apply_reset();
    pf_v_i = 1'b1; pf_addr_i = 32'hB000;
    demand_v_i = 1'b1; demand_addr_i = 32'hB010;
    tick();
    pf_v_i = 1'b0; demand_v_i = 1'b0;
    n_tests++;
    if (dma_snap() !== {2'b10, 32'hB010} || queue_count_o !== 3'd1) begin
      n_fail++;
      $display("FAIL same_cycle_push: got %h cnt=%0d, expected %h cnt=1", dma_snap(), queue_count_o, {2'b10, 32'hB010});
    end
    tick(); tick(); tick();
    n_tests++;
    if ({dma_v_o, queue_count_o} !== {1'b0, 3'd0}) begin
      n_fail++; $display("FAIL same_cycle_squashed: got v=%b cnt=%0d, expected v=0 cnt=0", dma_v_o, queue_count_o);
    end
  endtask

  task automatic test_priority();
    apply_reset();
    pf_v_i = 1'b1; pf_addr_i = 32'h6000;
    tick();
    pf_v_i = 1'b0;
    demand_v_i = 1'b1; demand_addr_i = 32'h6100;
    tick();
    demand_v_i = 1'b0;
    n_tests++;
    if (dma_snap() !== {2'b10, 32'h6100}) begin
      n_fail++; $display("FAIL priority_demand: got %h, expected %h", dma_snap(), {2'b10, 32'h6100});
    end
    tick(); tick();
    n_tests++;
    if (dma_snap() !== {2'b11, 32'h6000}) begin
      n_fail++; $display("FAIL priority_pf_after: got %h, expected %h", dma_snap(), {2'b11, 32'h6000});
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    demand_v_i = 1'b1; demand_addr_i = 32'hD000;
    tick();
    demand_addr_i = 32'hD040;
    tick();
    n_tests++;
    if ({dma_v_o, demand_ready_o} !== 2'b01) begin
      n_fail++; $display("FAIL b2b_gap: got v=%b rdy=%b, expected v=0 rdy=1", dma_v_o, demand_ready_o);
    end
    tick();
    demand_v_i = 1'b0;
    n_tests++;
    if (dma_snap() !== {2'b10, 32'hD040}) begin
      n_fail++; $display("FAIL b2b_second: got %h, expected %h", dma_snap(), {2'b10, 32'hD040});
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    pf_v_i = 1'b1; pf_addr_i = 32'h7000;
    tick();
    pf_v_i = 1'b0;
    tick(); tick();
    dma_ready_i = 1'b0;
    demand_v_i = 1'b1; demand_addr_i = 32'h8000;
    tick();
    demand_v_i = 1'b0;
    pf_v_i = 1'b1; pf_addr_i = 32'h7040;
    tick();
    pf_v_i = 1'b0;
    n_tests++;
    if ({dma_v_o, queue_count_o, outstanding_o} !== {1'b1, 3'd1, 2'd1}) begin
      n_fail++;
      $display("FAIL pre_reset_state: got v=%b cnt=%0d out=%0d, expected v=1 cnt=1 out=1",
               dma_v_o, queue_count_o, outstanding_o);
    end
    #2 reset_i = 1'b1;
    #1;
    n_tests++;
    if ({dma_v_o, queue_count_o, outstanding_o, demand_ready_o} !== 7'b0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b cnt=%0d out=%0d rdy=%b, expected all 0",
               dma_v_o, queue_count_o, outstanding_o, demand_ready_o);
    end
    tick();
    reset_i = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset_i = 1'b1;
    test_reset();
    test_demand();
    test_prefetch();
    test_duplicate();
    test_pending_dup();
    test_queue_full();
    test_limit();
    test_squash();
    test_same_cycle_squash();
    test_priority();
    test_back_to_back();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
